// File: rtl/adder_pipe_if.sv
// Handshake and data bundle for adder_pipe: operand/control inputs and result outputs.
// The slave side is the adder; the master side is whoever drives operands and consumes results.
interface adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             of;
    logic             of_sticky;
    logic             sticky_clr;

    modport master (
        output in_valid, a, b, mode, acc_clr, out_ready, sticky_clr,
        input  in_ready, out_valid, sum, of, of_sticky
    );

    modport slave (
        input  in_valid, a, b, mode, acc_clr, out_ready, sticky_clr,
        output in_ready, out_valid, sum, of, of_sticky
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined signed adder with wrap/saturate/accumulate modes, valid/ready flow control,
// sticky overflow and a PLL-lock gate that flushes in-flight results and the accumulator.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        locked,
    adder_pipe_if.slave bus
);
    localparam logic [1:0]       MODE_SAT = 2'b01;
    localparam logic [1:0]       MODE_ACC = 2'b10;
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    logic              in_ready;
    logic              advance;
    logic              out_xfer;
    logic              is_acc;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  acc_eff;
    logic [WIDTH-1:0]  add_x;
    logic [WIDTH-1:0]  add_y;
    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  result;
    logic              ovf;
    logic              of_sticky_q;
    logic              of_sticky_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] of_q;
    logic [WIDTH-1:0]  sum_q [STAGES];

    // Global stall: every stage moves only when the output slot is free or being drained.
    assign in_ready = rst_n & locked & (~valid_q[STAGES-1] | bus.out_ready);
    assign advance  = in_ready;
    assign out_xfer = valid_q[STAGES-1] & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.of        = of_q[STAGES-1];
    assign bus.of_sticky = of_sticky_q;

    always_comb begin
        is_acc  = (bus.mode == MODE_ACC);
        // A clear arriving with an ACC operand takes effect before the add.
        acc_eff = bus.acc_clr ? '0 : acc_q;
        add_x   = is_acc ? acc_eff : bus.a;
        add_y   = is_acc ? bus.a : bus.b;
        raw     = add_x + add_y;
        ovf     = (add_x[WIDTH-1] == add_y[WIDTH-1]) & (raw[WIDTH-1] != add_x[WIDTH-1]);
        result  = raw;
        if ((bus.mode == MODE_SAT) && ovf) begin
            result = add_x[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (!locked) begin
            acc_d = '0;
        end else if (advance && bus.in_valid && is_acc) begin
            acc_d = raw;
        end else if (bus.acc_clr) begin
            acc_d = '0;
        end
    end

    always_comb begin
        of_sticky_d = of_sticky_q;
        if (bus.sticky_clr) begin
            of_sticky_d = 1'b0;
        end
        if (out_xfer && of_q[STAGES-1]) begin
            of_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            of_sticky_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            of_sticky_q <= of_sticky_d;
        end
    end

    // Data only moves on advance, so sum/of stay frozen while the output is stalled.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            of_q    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= '0;
            end
        end else if (!locked) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q[0] <= bus.in_valid;
            sum_q[0]   <= result;
            of_q[0]    <= ovf;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                sum_q[i]   <= sum_q[i-1];
                of_q[i]    <= of_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed plan vectors plus randomized traffic,
// checked every cycle against an occupancy/arithmetic reference model.
module tb_adder_pipe;
    localparam int W   = 32;
    localparam int STG = 2;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct {
        logic [W-1:0] s;
        logic         o;
        int           age;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    logic locked;

    adder_pipe_if #(.WIDTH(W)) bus ();

    adder_pipe #(.WIDTH(W), .STAGES(STG)) dut (
        .refclk (clk),
        .rst_n  (rst_n),
        .locked (locked),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    item_t        q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] acc_m;
    logic         sticky_m;
    logic         last_acc;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_out = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] m, input logic clr, input logic ordy, input logic sclr);
        bus.in_valid   = v;
        bus.a          = a;
        bus.b          = b;
        bus.mode       = m;
        bus.acc_clr    = clr;
        bus.out_ready  = ordy;
        bus.sticky_clr = sclr;
    endtask

    // Signed arithmetic reference: widen to 64 bits, detect range overflow, clamp or wrap.
    task automatic model_xfer(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] m, input logic clr);
        logic signed [W-1:0] xa;
        logic signed [W-1:0] ya;
        longint              t;
        item_t               it;
        if (m == 2'b10) begin
            xa = clr ? '0 : acc_m;
            ya = a;
        end else begin
            xa = a;
            ya = b;
        end
        t    = longint'(xa) + longint'(ya);
        it.o = (t > MAXV) || (t < MINV);
        it.s = t[W-1:0];
        if (m == 2'b01 && it.o) it.s = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        if (m == 2'b10) acc_m = t[W-1:0];
        it.age = 1;
        q.push_back(it);
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic step();
        logic  exp_ov;
        logic  exp_ir;
        logic  oxfer;
        item_t it;
        #1;
        exp_ov = (q.size() > 0) && (q[0].age == STG);
        exp_ir = locked && (!exp_ov || bus.out_ready);
        chk("out_valid", bus.out_valid, exp_ov);
        chk("in_ready", bus.in_ready, exp_ir);
        chk("of_sticky", bus.of_sticky, sticky_m);
        if (exp_ov) begin
            chk("sum", bus.sum, q[0].s);
            chk("of", bus.of, q[0].o);
        end
        oxfer    = exp_ov && bus.out_ready;
        last_acc = exp_ir && bus.in_valid;
        if (bus.sticky_clr) sticky_m = 1'b0;
        if (oxfer) begin
            it = q.pop_front();
            if (it.o) sticky_m = 1'b1;
            hist.push_back(it.s);
            n_out++;
            $display("xfer #%0d sum=%08h of=%0b", n_out, it.s, it.o);
        end
        if (exp_ir) begin
            foreach (q[i]) q[i].age = q[i].age + 1;
        end
        if (last_acc) model_xfer(bus.a, bus.b, bus.mode, bus.acc_clr);
        if (bus.acc_clr && !(last_acc && bus.mode == 2'b10)) acc_m = '0;
        if (!locked) begin
            q.delete();
            acc_m = '0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] m, input logic clr);
        int n = 0;
        drv(1'b1, a, b, m, clr, 1'b1, 1'b0);
        do begin
            step();
            n++;
        end while (!last_acc && n < 20);
        chk("send_accept", last_acc, 1'b1);
    endtask

    task automatic drain(input int n);
        drv(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat [4];
        logic [W-1:0] corner [5];
        int sent;
        int budget;
        acc_m    = '0;
        sticky_m = 1'b0;
        last_acc = 1'b0;
        rst_n    = 1'b0;
        locked   = 1'b1;
        drv(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum", bus.sum, 32'h0);
        chk("rst_of", bus.of, 1'b0);
        chk("rst_sticky", bus.of_sticky, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b1;

        hist.delete();
        send(32'd5, 32'd3, 2'b00, 1'b0);
        drain(3);
        chk("wrap_5p3", hist[0], 32'h8);

        hist.delete();
        send(32'h7FFF_FFFF, 32'h1, 2'b00, 1'b0);
        drain(3);
        chk("wrap_ovf", hist[0], 32'h8000_0000);
        chk("sticky_set", bus.of_sticky, 1'b1);
        drv(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b1);
        step();
        drain(1);

        hist.delete();
        send(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 1'b0);
        send(32'h7FFF_FFF0, 32'h20, 2'b01, 1'b0);
        drain(3);
        chk("sat_neg", hist[0], 32'h8000_0000);
        chk("sat_pos", hist[1], 32'h7FFF_FFFF);

        hist.delete();
        drv(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
        step();
        send(32'd10, 32'd0, 2'b10, 1'b0);
        send(32'd20, 32'd0, 2'b10, 1'b0);
        send(-32'sd5, 32'd0, 2'b10, 1'b0);
        send(32'd7, 32'd0, 2'b10, 1'b1);
        drain(3);
        chk("acc_10", hist[0], 32'd10);
        chk("acc_30", hist[1], 32'd30);
        chk("acc_25", hist[2], 32'd25);
        chk("acc_clr7", hist[3], 32'd7);

        // Backpressure: out_ready follows 1,0,0,1 while 8 operands stream in.
        pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;
        hist.delete();
        sent   = 0;
        budget = 0;
        while (sent < 8 && budget < 100) begin
            drv(1'b1, 32'(100 * sent), 32'(sent), 2'b00, 1'b0, pat[budget % 4][0], 1'b0);
            step();
            if (last_acc) sent++;
            budget++;
        end
        drain(4);
        chk("bp_count", 64'(hist.size()), 64'd8);
        for (int i = 0; i < 8 && i < hist.size(); i++) chk("bp_order", hist[i], 32'(101 * i));

        // Lock loss with two results in flight, then recovery.
        hist.delete();
        drv(1'b1, 32'd11, 32'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        step();
        drv(1'b1, 32'd22, 32'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        step();
        locked = 1'b0;
        drv(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        step();
        locked = 1'b1;
        send(32'd4, 32'd0, 2'b10, 1'b0);
        send(32'd1, 32'd1, 2'b00, 1'b0);
        drain(3);
        chk("lock_drop_cnt", 64'(hist.size()), 64'd2);
        chk("lock_acc_zero", hist[0], 32'd4);
        chk("lock_1p1", hist[1], 32'd2);

        corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h0;         corner[4] = 32'h1;
        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            locked = ($urandom_range(0, 29) != 0);
            drv(1'($urandom_range(0, 3) != 0), ra, rb, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0));
            step();
            if (i == 250) begin
                #2 rst_n = 1'b0;
                #1;
                chk("arst_out_valid", bus.out_valid, 1'b0);
                chk("arst_sum", bus.sum, 32'h0);
                chk("arst_of", bus.of, 1'b0);
                chk("arst_sticky", bus.of_sticky, 1'b0);
                chk("arst_in_ready", bus.in_ready, 1'b0);
                q.delete();
                acc_m    = '0;
                sticky_m = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        locked = 1'b1;
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
